// File: rtl/mem_io_responder.sv
// mem_io_responder: responder end of the byte-wide CPU memory bus.
// RAM bytes are served with a fixed one-cycle read latency. Addresses with
// bits [17:16] == 2'b11 form the IO window. In that window, offset 0x0000 is
// the TX/RX data port and offset 0x0004 is the status register.
// Define IO_RX_EN to build the optional RX byte FIFO behind the data port.
// Without it, RX reads return zero and rx_ready is tied low.
module mem_io_responder #(
  parameter int RAM_ADDR_W  = 17,
  parameter int FIFO_DEPTH  = 8,
  parameter int FULL_MARGIN = 2
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic        rdy_in,
  input  logic [31:0] mem_addr,
  input  logic        mem_wr,
  input  logic [7:0]  mem_wdata,
  output logic [7:0]  mem_rdata,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [15:0] IO_DATA = 16'h0000;
  localparam logic [15:0] IO_STAT = 16'h0004;

  logic [7:0]            ram [2**RAM_ADDR_W];
  logic [RAM_ADDR_W-1:0] ram_idx;
  logic                  is_io;
  logic [15:0]           io_off;
  logic [7:0]            rd_next;
  logic                  unused_in;

  assign is_io   = (mem_addr[17:16] == 2'b11);
  assign io_off  = mem_addr[15:0];
  assign ram_idx = mem_addr[RAM_ADDR_W-1:0];

  // TX FIFO state
  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [PW-1:0] tx_wr_ptr, tx_rd_ptr;
  logic [CW-1:0] tx_count, tx_count_next;
  logic          tx_full, tx_push, tx_pop;

  // RX FIFO view seen by the read mux (constant zero when RX is not built)
  logic          rx_nonempty;
  logic [7:0]    rx_head;

  assign tx_full  = (tx_count == CW'(FIFO_DEPTH));
  assign tx_valid = !rst && (tx_count != '0);
  assign tx_data  = tx_mem[tx_rd_ptr];
  assign tx_pop   = rdy_in && tx_valid && tx_ready;
  // A push into a full FIFO is still accepted when a pop frees a slot in the same cycle
  assign tx_push  = rdy_in && is_io && mem_wr && (io_off == IO_DATA) && (!tx_full || tx_pop);
  assign tx_count_next = tx_count + CW'(tx_push) - CW'(tx_pop);

  // RAM write port; the old byte is captured separately by the read register
  always_ff @(posedge clk_in) begin
    if (!rst && rdy_in && !is_io && mem_wr) ram[ram_idx] <= mem_wdata;
  end

  // Read data selection for the access presented this cycle (IO writes leave it unchanged)
  always_comb begin
    rd_next = mem_rdata;
    if (!is_io) begin
      rd_next = ram[ram_idx];
    end else if (!mem_wr) begin
      if (io_off == IO_DATA)      rd_next = rx_nonempty ? rx_head : 8'h00;
      else if (io_off == IO_STAT) rd_next = {6'b0, rx_nonempty, tx_full};
      else                        rd_next = 8'h00;
    end
  end

  // Registered bus read data, frozen while rdy_in is low
  always_ff @(posedge clk_in) begin
    if (rst)         mem_rdata <= 8'h00;
    else if (rdy_in) mem_rdata <= rd_next;
  end

  // TX storage write; entries need no reset because the count gates validity
  always_ff @(posedge clk_in) begin
    if (!rst && tx_push) tx_mem[tx_wr_ptr] <= mem_wdata;
  end

  // TX pointers, occupancy and the registered near-full flag for the controller
  always_ff @(posedge clk_in) begin
    if (rst) begin
      tx_wr_ptr      <= '0;
      tx_rd_ptr      <= '0;
      tx_count       <= '0;
      io_buffer_full <= 1'b0;
    end else if (rdy_in) begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + PW'(1);
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + PW'(1);
      tx_count       <= tx_count_next;
      io_buffer_full <= (tx_count_next >= CW'(FIFO_DEPTH - FULL_MARGIN));
    end
  end

`ifdef IO_RX_EN
  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [PW-1:0] rx_wr_ptr, rx_rd_ptr;
  logic [CW-1:0] rx_count;
  logic          rx_full, rx_push, rx_pop;

  assign rx_full     = (rx_count == CW'(FIFO_DEPTH));
  assign rx_nonempty = (rx_count != '0);
  assign rx_head     = rx_mem[rx_rd_ptr];
  assign rx_ready    = !rst && !rx_full;
  assign rx_push     = rdy_in && rx_valid && rx_ready;
  assign rx_pop      = rdy_in && is_io && !mem_wr && (io_off == IO_DATA) && rx_nonempty;
  assign unused_in   = ^mem_addr[31:18];

  // RX storage write
  always_ff @(posedge clk_in) begin
    if (!rst && rx_push) rx_mem[rx_wr_ptr] <= rx_data;
  end

  // RX pointers and occupancy
  always_ff @(posedge clk_in) begin
    if (rst) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
    end else if (rdy_in) begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + PW'(1);
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + PW'(1);
      rx_count <= rx_count + CW'(rx_push) - CW'(rx_pop);
    end
  end
`else
  assign rx_nonempty = 1'b0;
  assign rx_head     = 8'h00;
  assign rx_ready    = 1'b0;
  assign unused_in   = ^{mem_addr[31:18], rx_data, rx_valid};
`endif

endmodule

// File: tb/tb_mem_io_responder.sv
// tb_mem_io_responder: directed bench for mem_io_responder with a queue
// scoreboard for bus read data and for the TX byte stream. Defining IO_RX_EN
// for the bench as well enables the RX FIFO steps.
module tb_mem_io_responder;

  logic        clk_in = 1'b0;
  logic        rst;
  logic        rdy_in;
  logic [31:0] mem_addr;
  logic        mem_wr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;

  int checks = 0;
  int errors = 0;

  // Scoreboard and reference state
  logic [7:0] rd_q [$];
  logic [7:0] tx_q [$];
  logic [7:0] rx_q [$];
  logic [7:0] ram_model [int];
  logic       model_full;
  logic [7:0] rd_last;
  logic       rd_known;

  mem_io_responder #(
    .RAM_ADDR_W (17),
    .FIFO_DEPTH (8),
    .FULL_MARGIN(2)
  ) dut (
    .clk_in        (clk_in),
    .rst           (rst),
    .rdy_in        (rdy_in),
    .mem_addr      (mem_addr),
    .mem_wr        (mem_wr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .io_buffer_full(io_buffer_full),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready)
  );

  always #5 clk_in = ~clk_in;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One bus access; reference model is evaluated against the pre-edge state
  task automatic applyStimulus(input logic [31:0] addr, input logic wr, input logic [7:0] wdata,
                               input logic rdy, input logic txr);
    logic       have_rd;
    logic [7:0] rd_exp;
    int         idx;
    mem_addr  = addr;
    mem_wr    = wr;
    mem_wdata = wdata;
    rdy_in    = rdy;
    tx_ready  = txr;
    #1;
    idx = int'(addr[16:0]);

    checkOutput("tx_valid", 32'(tx_valid), 32'(tx_q.size() != 0));
`ifdef IO_RX_EN
    checkOutput("rx_ready", 32'(rx_ready), 32'(rx_q.size() < 8));
`else
    checkOutput("rx_ready", 32'(rx_ready), 32'(0));
`endif

    have_rd = 1'b0;
    rd_exp  = 8'h00;
    if (rdy) begin
      if (addr[17:16] != 2'b11) begin
        if (ram_model.exists(idx)) begin
          have_rd = 1'b1;
          rd_exp  = ram_model[idx];
        end
        if (wr) ram_model[idx] = wdata;
      end else if (!wr) begin
        have_rd = 1'b1;
        if (addr[15:0] == 16'h0000) begin
          if (rx_q.size() != 0) rd_exp = rx_q.pop_front();
        end else if (addr[15:0] == 16'h0004) begin
          rd_exp = {6'b0, rx_q.size() != 0, tx_q.size() == 8};
        end
      end
      if (have_rd) begin
        rd_last  = rd_exp;
        rd_known = 1'b1;
        rd_q.push_back(rd_exp);
      end else begin
        rd_known = 1'b0;
      end
    end else if (rd_known) begin
      rd_q.push_back(rd_last);
    end

    if (rdy && txr && tx_q.size() != 0) begin
      checkOutput("tx_data", 32'(tx_data), 32'(tx_q.pop_front()));
    end
    if (rdy && wr && addr == 32'h0003_0000 && tx_q.size() < 8) tx_q.push_back(wdata);
`ifdef IO_RX_EN
    if (rdy && rx_valid && rx_q.size() < 8) rx_q.push_back(rx_data);
`endif

    @(posedge clk_in);
    #1;
    if (rdy) model_full = (tx_q.size() >= 6);
    checkOutput("io_buffer_full", 32'(io_buffer_full), 32'(model_full));
    if (rd_q.size() != 0) checkOutput("mem_rdata", 32'(mem_rdata), 32'(rd_q.pop_front()));
  endtask

  task automatic doReset();
    rst       = 1'b1;
    rdy_in    = 1'b1;
    mem_addr  = 32'h0000_0010;
    mem_wr    = 1'b0;
    mem_wdata = 8'h00;
    tx_ready  = 1'b0;
    rx_valid  = 1'b0;
    rx_data   = 8'h00;
    @(posedge clk_in);
    #1;
    tx_q.delete();
    rx_q.delete();
    rd_q.delete();
    model_full = 1'b0;
    rd_last    = 8'h00;
    rd_known   = 1'b1;
    checkOutput("rst_tx_valid", 32'(tx_valid), 32'(0));
    checkOutput("rst_io_buffer_full", 32'(io_buffer_full), 32'(0));
    checkOutput("rst_mem_rdata", 32'(mem_rdata), 32'(0));
    checkOutput("rst_rx_ready", 32'(rx_ready), 32'(0));
    rst = 1'b0;
  endtask

  initial begin
    doReset();

    // Single RAM byte write then read
    applyStimulus(32'h0000_0010, 1'b1, 8'hA5, 1'b1, 1'b0);
    applyStimulus(32'h0000_0010, 1'b0, 8'h00, 1'b1, 1'b0);

    // Four-byte burst and read-back in address order
    for (int i = 0; i < 4; i++) applyStimulus(32'h100 + 32'(i), 1'b1, 8'h11 * 8'(i + 1), 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(32'h100 + 32'(i), 1'b0, 8'h00, 1'b1, 1'b0);
    // Read-before-write on a known byte
    applyStimulus(32'h0000_0101, 1'b1, 8'h99, 1'b1, 1'b0);
    applyStimulus(32'h0000_0101, 1'b0, 8'h00, 1'b1, 1'b0);

    // Fill TX with the sink stalled: near-full after the 6th, 9th byte dropped
    for (int i = 0; i < 9; i++) applyStimulus(32'h0003_0000, 1'b1, 8'h50 + 8'(i), 1'b1, 1'b0);
    applyStimulus(32'h0003_0004, 1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulus(32'h0003_0008, 1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulus(32'h0003_0004, 1'b1, 8'hFF, 1'b1, 1'b0);
    // Push into a full FIFO with a simultaneous pop is accepted
    applyStimulus(32'h0003_0000, 1'b1, 8'h59, 1'b1, 1'b1);
    // Drain everything in push order
    for (int i = 0; i < 9; i++) applyStimulus(32'h0000_0010, 1'b0, 8'h00, 1'b1, 1'b1);

    // Push+pop at count 5 keeps the count at 5
    for (int i = 0; i < 5; i++) applyStimulus(32'h0003_0000, 1'b1, 8'h60 + 8'(i), 1'b1, 1'b0);
    applyStimulus(32'h0003_0000, 1'b1, 8'h65, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) applyStimulus(32'h0000_0010, 1'b0, 8'h00, 1'b1, 1'b1);

    // rdy_in low in the middle of a write stream freezes everything
    applyStimulus(32'h0000_0200, 1'b1, 8'h77, 1'b1, 1'b0);
    applyStimulus(32'h0000_0201, 1'b1, 8'h78, 1'b1, 1'b0);
    applyStimulus(32'h0003_0000, 1'b1, 8'h70, 1'b1, 1'b0);
    applyStimulus(32'h0003_0000, 1'b1, 8'h71, 1'b1, 1'b0);
    applyStimulus(32'h0000_0200, 1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) applyStimulus(32'h0003_0000, 1'b1, 8'hEF, 1'b0, 1'b1);
      else        applyStimulus(32'h0000_0200 + 32'(i & 1), 1'b1, 8'hEE, 1'b0, 1'b1);
    end
    applyStimulus(32'h0000_0200, 1'b0, 8'h00, 1'b1, 1'b1);
    applyStimulus(32'h0000_0201, 1'b0, 8'h00, 1'b1, 1'b1);
    applyStimulus(32'h0000_0010, 1'b0, 8'h00, 1'b1, 1'b1);

    // Reset with bytes queued clears the FIFO but keeps RAM
    for (int i = 0; i < 3; i++) applyStimulus(32'h0003_0000, 1'b1, 8'h80 + 8'(i), 1'b1, 1'b0);
    doReset();
    applyStimulus(32'h0000_0010, 1'b0, 8'h00, 1'b1, 1'b1);
    applyStimulus(32'h0000_0103, 1'b0, 8'h00, 1'b1, 1'b1);

`ifdef IO_RX_EN
    // RX bytes arrive, then are read out through the data port
    rx_valid = 1'b1;
    rx_data  = 8'h41;
    applyStimulus(32'h0000_0010, 1'b0, 8'h00, 1'b1, 1'b0);
    rx_data  = 8'h42;
    applyStimulus(32'h0000_0010, 1'b0, 8'h00, 1'b1, 1'b0);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    applyStimulus(32'h0003_0004, 1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(32'h0003_0000, 1'b0, 8'h00, 1'b1, 1'b0);
`else
    // RX inputs are ignored and the data port reads zero
    rx_valid = 1'b1;
    rx_data  = 8'h41;
    applyStimulus(32'h0000_0010, 1'b0, 8'h00, 1'b1, 1'b0);
    rx_valid = 1'b0;
    applyStimulus(32'h0003_0000, 1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulus(32'h0003_0004, 1'b0, 8'h00, 1'b1, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
